ram8: RTL
=========

// Module: ram8
// PURPOSE
//  - Eight-word register file. It is the direct consumer of the 1:2 load demultiplexer
//    stage, built out to an 8-way load decode.
//  - The load strobe is demultiplexed by address to one of eight WIDTH-bit registers.
//    Read data is an 8-way multiplex of the register outputs.
//  - This is the first memory level of the CPU data path. ram64 and larger stacks
//    instantiate this block.
// PARAMETERS
//  WIDTH   16   bits per word (in, out, each register)
// PORTS
//  clk      input   1      rising-edge clock; all register updates occur on this edge
//  reset    input   1      asynchronous, active-high; clears all eight registers
//  in       input   WIDTH  write data
//  load     input   1      write strobe; sampled on rising clk
//  address  input   3      word select for both read and write (0..7)
//  out      output  WIDTH  read data for word[address]
// BEHAVIOUR
//  - Reset: reset=1 forces word[0..7] to 0 immediately, without waiting for clk.
//    out reads 0 while reset is held. Reset dominates load on any edge.
//  - Write decode: the 1-bit load is routed through an 8-way demux on address.
//    Exactly one register load enable (ld[address]) may be high. All others are 0.
//  - Write: on rising clk with reset=0 and load=1, word[address] <= in.
//    The other seven words hold their value.
//  - No write: load=0 leaves all words unchanged. in and address are don't-care.
//  - Read: out = word[address], combinational, with zero-cycle latency from an
//    address change.
//  - Read-during-write, default build:
//    - out shows the OLD content of word[address] until the edge.
//    - The new value appears after the edge.
//    - Write latency is 1 cycle.
//  - Address changes between edges have no effect on storage. Only the value present
//    at the rising edge selects the written word.
//  - Reset asserted mid-sequence: all pending and prior writes are lost.
//    After reset deasserts, the first rising clk with load=1 writes normally.
//  - No wrap or overflow conditions exist. address is fully decoded (3 bits = 8 words).
//  - Width rules: in, out and the words are exactly WIDTH bits. No truncation or extension.
//  - Structure: 8 WIDTH-bit registers (load-enabled DFFs), an 8-way 1-bit demux on load,
//    and an 8-way WIDTH-bit mux on the read path. No other state.
// CONFIGURATION
//  RAM8_WRITE_THROUGH_EN
//  - Defined:
//    - When load=1 and reset=0, out = in (combinational bypass) for the addressed word
//      during the write cycle.
//    - After the edge, out = stored value, which equals that same in.
//  - Undefined: default read-old behaviour as above.
//  - Storage behaviour is identical in both builds. Only out during a load cycle differs.
// TESTING
//  1. Reset: assert reset=1 asynchronously between edges -> out=0 at every address 0..7
//     with no clk edge.
//  2. Write/readback: load=1, write 16'h0001..16'h0008 to addresses 0..7 on successive
//     edges; then load=0 and sweep address -> out = 16'h0001..16'h0008.
//  3. Isolation: write 16'hBEEF to address 5 over previous data -> address 5 = 16'hBEEF,
//     all other addresses unchanged.
//  4. Read-during-write: address=3 holds 16'h0004; present in=16'h1234, load=1
//     -> out=16'h0004 before the edge (out=16'h1234 if RAM8_WRITE_THROUGH_EN), and
//     16'h1234 after the edge.
//  5. load=0 hold: in=16'hFFFF, address cycled 0..7 for 8 edges -> no word changes.
//  6. Mid-op reset: write 16'hAAAA to address 2, pulse reset between edges -> address 2
//     reads 0. Next write of 16'h5555 then reads back 16'h5555.

Source files
------------

// File: rtl/ram8.sv
// ram8: eight-word register file, first memory level of the CPU data path.
// The load strobe is demultiplexed by address to one of eight WIDTH-bit
// registers, and the read port is an 8-way combinational multiplex.
// Optional build macro: RAM8_WRITE_THROUGH_EN. When it is defined, a write
// cycle shows the incoming data on out before the edge. When it is undefined,
// out shows the old word until the edge.
`timescale 1ns/1ps

module ram8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned DEPTH = 8;

  logic [WIDTH-1:0] word [DEPTH];
  logic [DEPTH-1:0] ld;
  logic [WIDTH-1:0] rd_word;

  // 1:8 demux of the load strobe; at most one enable is high
  always_comb begin
    ld          = '0;
    ld[address] = load;
  end

  // Load-enabled word registers; asynchronous reset clears every word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word[3'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ld[3'(i)]) begin
          word[3'(i)] <= in;
        end
      end
    end
  end

  // 8:1 read multiplex with zero-cycle latency from address
  always_comb begin
    rd_word = word[address];
  end

`ifdef RAM8_WRITE_THROUGH_EN
  // Read port with bypass: a write in progress shows the incoming data
  always_comb begin
    out = rd_word;
    if (load && !reset) begin
      out = in;
    end
  end
`else
  // Read port: a write in progress still shows the old word until the edge
  always_comb begin
    out = rd_word;
  end
`endif

endmodule
